dffq_chain_bist: RTL and testbench

DFFQ_CHAIN_BIST -- requirements
Module: dffq_chain_bist

---
 rtl/dffq_chain_bist_pkg.sv | 15 +
 rtl/dffq_bist_lfsr.sv | 36 +++
 rtl/dffq_chain_bist.sv | 126 ++++++++++++
 tb/tb_dffq_chain_bist.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dffq_chain_bist_pkg.sv
// Shared definitions for the dffq chain BIST: FSM states and LFSR constants.
// The tap mask selects bits 0,2,3,5 for x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci LFSR.
package dffq_chain_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/dffq_bist_lfsr.sv
// 16-bit Fibonacci LFSR pattern source; LOAD reloads the seed, EN advances one step.
module dffq_bist_lfsr
   import dffq_chain_bist_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD,
   input  logic        EN,
   output logic [15:0] STATE
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic        feedback;

   always_comb begin
      feedback = ^(state_q & LFSR_TAPS);
      state_d  = state_q;
      if (LOAD) begin
         state_d = LFSR_SEED;
      end else if (EN) begin
         state_d = {feedback, state_q[15:1]};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign STATE = state_q;

endmodule

// File: rtl/dffq_chain_bist.sv
// BIST controller for an external chain of DEPTH flops: drives LFSR data in, waits for the
// chain to fill, then compares the chain output against an internal reference delay line.
module dffq_chain_bist
   import dffq_chain_bist_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ERR_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [15:0]      PATTERN_LEN,
   output logic             CHAIN_D,
   input  logic             CHAIN_Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT
);

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   bist_state_e      state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [6:0]       fill_q, fill_d;
   logic [15:0]      chk_q, chk_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [DEPTH-1:0] dly_q;
   logic [15:0]      lfsr_state;
   logic             accept;
   logic             running;
   logic             mismatch;
   logic             chain_d_int;
   logic             unused_lfsr_hi;

   assign accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && START;
   assign running  = (state_q == ST_FILL) || (state_q == ST_CHECK);
   assign mismatch = CHAIN_Q != dly_q[DEPTH-1];

   dffq_bist_lfsr u_lfsr (
      .CLK   (CLK),
      .RST   (RST),
      .LOAD  (accept),
      .EN    (running),
      .STATE (lfsr_state)
   );

   assign unused_lfsr_hi = ^lfsr_state[15:1];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         fill_q  <= '0;
         chk_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         chk_q   <= chk_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (fill_q == 7'(DEPTH - 1)) begin
               state_d = (len_q == 16'd0) ? ST_DONE : ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (chk_q == len_q - 16'd1) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters and error accumulation; the error count saturates instead of wrapping.
   always_comb begin
      len_d  = len_q;
      fill_d = fill_q;
      chk_d  = chk_q;
      err_d  = err_q;
      if (accept) begin
         len_d  = PATTERN_LEN;
         fill_d = '0;
         chk_d  = '0;
         err_d  = '0;
      end else if (state_q == ST_FILL) begin
         fill_d = fill_q + 7'd1;
      end else if (state_q == ST_CHECK) begin
         chk_d = chk_q + 16'd1;
         if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
      end
   end

   always_comb begin
      BUSY        = running;
      DONE        = (state_q == ST_DONE);
      PASS        = (state_q == ST_DONE) && (err_q == '0);
      chain_d_int = running ? lfsr_state[0] : 1'b0;
   end

   assign CHAIN_D = chain_d_int;
   assign ERR_CNT = err_q;

   // Reference delay line: stage DEPTH-1 holds the bit driven DEPTH cycles ago, matching CHAIN_Q.
   always_ff @(posedge CLK) begin
      if (RST) dly_q[0] <= 1'b0;
      else     dly_q[0] <= chain_d_int;
   end

   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_dly
      always_ff @(posedge CLK) begin
         if (RST) dly_q[gi] <= 1'b0;
         else     dly_q[gi] <= dly_q[gi-1];
      end
   end

endmodule

// File: tb/tb_dffq_chain_bist.sv
// Bench for dffq_chain_bist: two instances (DEPTH 8 / ERR_W 16 and DEPTH 4 / ERR_W 8) driving
// behavioural flop chains, checked every cycle against a run-level model plus literal checks.
module tb_dffq_chain_bist;

   localparam int DA = 8;
   localparam int DB = 4;
   localparam int EWA = 16;
   localparam int EWB = 8;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic            rst_a = 1'b1, rst_b = 1'b1, start_a = 1'b0, start_b = 1'b0;
   logic [15:0]     len_a = '0, len_b = '0;
   logic            inv_a = 1'b0, inv_b = 1'b0;
   logic            d_a, q_a, busy_a, done_a, pass_a;
   logic            d_b, q_b, busy_b, done_b, pass_b;
   logic [EWA-1:0]  err_a;
   logic [EWB-1:0]  err_b;
   logic [DA-1:0]   ch_a = '0;
   logic [DB-1:0]   ch_b = '0;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   logic seen [8];

   dffq_chain_bist #(.DEPTH(DA), .ERR_W(EWA)) dut_a (
      .CLK(CLK), .RST(rst_a), .START(start_a), .PATTERN_LEN(len_a), .CHAIN_D(d_a),
      .CHAIN_Q(q_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a));

   dffq_chain_bist #(.DEPTH(DB), .ERR_W(EWB)) dut_b (
      .CLK(CLK), .RST(rst_b), .START(start_b), .PATTERN_LEN(len_b), .CHAIN_D(d_b),
      .CHAIN_Q(q_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b));

   // External chains under test, with an optional inverting fault on the last stage output.
   always @(posedge CLK) begin
      ch_a <= {ch_a[DA-2:0], d_a};
      ch_b <= {ch_b[DB-2:0], d_b};
   end
   assign q_a = ch_a[DA-1] ^ inv_a;
   assign q_b = ch_b[DB-1] ^ inv_b;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Run-level model: a run is counted in cycles since acceptance; cycles DEPTH+1..DEPTH+LEN
   // compare the chain output with the bit the model itself drove DEPTH cycles earlier.
   int          m_run [2] = '{0, 0};
   int          m_done[2] = '{0, 0};
   int          m_err [2] = '{0, 0};
   int          m_t   [2] = '{0, 0};
   int          m_len [2] = '{0, 0};
   int          m_dep [2] = '{DA, DB};
   int          m_max [2] = '{65535, 255};
   logic [15:0] m_lfsr[2] = '{16'hACE1, 16'hACE1};
   logic [63:0] m_hist[2] = '{64'd0, 64'd0};

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic b;
      b = s[0] ^ s[2] ^ s[3] ^ s[5];
      return (s >> 1) | (16'(b) << 15);
   endfunction

   task automatic model_step(input int i, input logic r, input logic s,
                             input logic [15:0] l, input logic q);
      logic d;
      d = (m_run[i] != 0) ? m_lfsr[i][0] : 1'b0;
      if (r) begin
         m_run[i] = 0; m_done[i] = 0; m_err[i] = 0; m_lfsr[i] = 16'hACE1; m_hist[i] = '0;
      end else begin
         if (m_run[i] != 0) begin
            if (m_t[i] > m_dep[i] && q !== m_hist[i][m_dep[i]-1] && m_err[i] < m_max[i])
               m_err[i]++;
            m_lfsr[i] = lfsr_next(m_lfsr[i]);
            if (m_t[i] == m_dep[i] + m_len[i]) begin
               m_run[i] = 0; m_done[i] = 1;
            end else begin
               m_t[i]++;
            end
         end else if (s) begin
            m_run[i] = 1; m_done[i] = 0; m_t[i] = 1; m_len[i] = int'(l);
            m_err[i] = 0; m_lfsr[i] = 16'hACE1;
         end
         m_hist[i] = {m_hist[i][62:0], d};
      end
   endtask

   always @(posedge CLK) begin
      model_step(0, rst_a, start_a, len_a, q_a);
      model_step(1, rst_b, start_b, len_b, q_b);
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("a_busy",  busy_a, m_run[0]);
         chk("a_done",  done_a, m_done[0]);
         chk("a_pass",  pass_a, (m_done[0] != 0 && m_err[0] == 0) ? 1 : 0);
         chk("a_err",   err_a,  m_err[0]);
         chk("a_chaind", d_a,   (m_run[0] != 0) ? m_lfsr[0][0] : 1'b0);
         chk("b_busy",  busy_b, m_run[1]);
         chk("b_done",  done_b, m_done[1]);
         chk("b_pass",  pass_b, (m_done[1] != 0 && m_err[1] == 0) ? 1 : 0);
         chk("b_err",   err_b,  m_err[1]);
         chk("b_chaind", d_b,   (m_run[1] != 0) ? m_lfsr[1][0] : 1'b0);
      end
   end

   task automatic drive(input int i, input logic s, input logic [15:0] l, input logic inv,
                        input logic r);
      if (i == 0) begin start_a = s; len_a = l; inv_a = inv; rst_a = r; end
      else        begin start_b = s; len_b = l; inv_b = inv; rst_b = r; end
   endtask

   // Starts a run (called #1 after a rising edge) and counts edges until DONE.
   // Optional fault window, mid-run reset cycle and ignored re-START cycle.
   task automatic run(input int i, input logic [15:0] len, input int f_from, input int f_to,
                      input int rst_at, input int restart_at, output int cyc);
      logic dn;
      drive(i, 1'b1, len, 1'b0, 1'b0);
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge CLK); #1;
         cyc++;
         dn = (i == 0) ? done_a : done_b;
         if (dn) break;
         if (cyc < 8) seen[cyc] = (i == 0) ? d_a : d_b;
         drive(i, cyc == restart_at, (cyc == restart_at) ? 16'd5 : len,
               cyc >= f_from && cyc <= f_to, cyc == rst_at);
         if (cyc == rst_at) begin
            @(posedge CLK); #1;
            drive(i, 1'b0, len, 1'b0, 1'b0);
            return;
         end
      end
      drive(i, 1'b0, len, 1'b0, 1'b0);
      if (cyc >= 2000) chk("run_timeout", cyc, -1);
   endtask

   int cyc;

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      chk_en = 1'b1;
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pass", pass_a, 0);
      chk("rst_err",  err_a,  0);
      chk("rst_chaind", d_a,  0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(posedge CLK); #1;

      run(0, 16'd100, -1, -1, -1, -1, cyc);
      $display("loopback: len=100 cycles=%0d err=%0d pass=%0d", cyc, err_a, pass_a);
      chk("loop_latency", cyc, 109);
      chk("loop_err", err_a, 0);
      chk("loop_pass", pass_a, 1);
      chk("first_bits", {seen[1], seen[2], seen[3], seen[4]}, 4'b1000);
      repeat (3) @(posedge CLK);
      #1;
      chk("done_hold", done_a, 1);
      chk("busy_low_in_done", busy_a, 0);

      run(0, 16'd20, 12, 12, -1, -1, cyc);
      $display("single fault: len=20 cycles=%0d err=%0d pass=%0d", cyc, err_a, pass_a);
      chk("fault_latency", cyc, 29);
      chk("fault_err", err_a, 1);
      chk("fault_pass", pass_a, 0);

      run(0, 16'd50, 10, 11, 20, -1, cyc);
      $display("reset mid-check: busy=%0d done=%0d err=%0d d=%0d", busy_a, done_a, err_a, d_a);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_done", done_a, 0);
      chk("midrst_err",  err_a,  0);
      chk("midrst_chaind", d_a,  0);
      run(0, 16'd30, -1, -1, -1, -1, cyc);
      $display("rerun after reset: len=30 cycles=%0d err=%0d pass=%0d", cyc, err_a, pass_a);
      chk("rerun_latency", cyc, 39);
      chk("rerun_err", err_a, 0);
      chk("rerun_pass", pass_a, 1);

      run(1, 16'd0, -1, -1, -1, 2, cyc);
      $display("zero length: depth=4 cycles=%0d err=%0d pass=%0d", cyc, err_b, pass_b);
      chk("zero_latency", cyc, 5);
      chk("zero_err", err_b, 0);
      chk("zero_pass", pass_b, 1);

      run(1, 16'd300, 0, 100000, -1, -1, cyc);
      $display("inverted chain: len=300 cycles=%0d err=%0d pass=%0d", cyc, err_b, pass_b);
      chk("inv_latency", cyc, 305);
      chk("inv_err_sat", err_b, 255);
      chk("inv_pass", pass_b, 0);

      @(posedge CLK); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
